// File: rtl/ygr_xfer_fifo.sv
// Bidirectional transfer FIFO for the CD block host interface.
// Side A = SCU host port, side B = SH-2 port with DMA burst request (DREQ_N/DACK).
module ygr_xfer_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned BURST = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       CTRL_WR,
  input  logic [2:0]                 CTRL_DI,
  input  logic                       A_WR,
  input  logic                       A_RD,
  input  logic [W-1:0]               A_DI,
  output logic [W-1:0]               A_DO,
  input  logic                       B_WR,
  input  logic                       B_RD,
  input  logic [W-1:0]               B_DI,
  output logic [W-1:0]               B_DO,
  input  logic                       DACK,
  output logic                       DREQ_N,
  output logic [$clog2(DEPTH):0]     LEVEL,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic                       OVF,
  output logic                       UNF
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] BURST_L = LW'(BURST);
  localparam logic [LW-1:0] LAST_BEAT = LW'(BURST - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_GAP} state_t;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [LW-1:0] level;
  logic [LW-1:0] beat_cnt;
  logic          dir, en;
  logic          ovf, unf;
  logic [W-1:0]  a_do, b_do;
  logic          dreq_n;
  state_t        state;

  logic          data_ok, wr_req, rd_req, rd_ok, wr_ok, beat, burst_ready, fsm_kill;
  logic [W-1:0]  wr_data;

  // CTRL_WR wins over data strobes in the same cycle; only the active pair is decoded.
  always_comb begin
    data_ok     = en & ~CTRL_WR;
    wr_req      = data_ok & (dir ? A_WR : B_WR);
    rd_req      = data_ok & (dir ? B_RD : A_RD);
    rd_ok       = rd_req & (level != '0);
    wr_ok       = wr_req & ((level != DEPTH_L) | rd_ok);
    beat        = data_ok & DACK & (dir ? B_RD : B_WR);
    wr_data     = dir ? A_DI : B_DI;
    burst_ready = dir ? (level >= BURST_L) : ((DEPTH_L - level) >= BURST_L);
    fsm_kill    = CTRL_WR & (CTRL_DI[1] | (CTRL_DI[0] != dir));
  end

  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wptr] <= wr_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
      a_do  <= '0;
      b_do  <= '0;
      dir   <= 1'b0;
      en    <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) begin
        rptr <= rptr + 1'b1;
        if (dir) b_do <= mem[rptr];
        else     a_do <= mem[rptr];
      end
      if (wr_req && !wr_ok) ovf <= 1'b1;
      if (rd_req && !rd_ok) unf <= 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (CTRL_WR) begin
        dir <= CTRL_DI[0];
        en  <= CTRL_DI[2];
        if (CTRL_DI[1]) begin
          wptr  <= '0;
          rptr  <= '0;
          level <= '0;
          ovf   <= 1'b0;
          unf   <= 1'b0;
        end
      end
    end
  end

  // Burst pacing: DREQ_N is low exactly while in REQ; GAP forces a high cycle between bursts.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      dreq_n   <= 1'b1;
    end else if (fsm_kill) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      dreq_n   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en && burst_ready) begin
            state    <= ST_REQ;
            dreq_n   <= 1'b0;
            beat_cnt <= '0;
          end
        end
        ST_REQ: begin
          if (!en) begin
            state  <= ST_IDLE;
            dreq_n <= 1'b1;
          end else if (beat) begin
            if (beat_cnt == LAST_BEAT) begin
              state    <= ST_GAP;
              dreq_n   <= 1'b1;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          state  <= ST_IDLE;
          dreq_n <= 1'b1;
        end
      endcase
    end
  end

  assign A_DO   = a_do;
  assign B_DO   = b_do;
  assign DREQ_N = dreq_n;
  assign LEVEL  = level;
  assign FULL   = (level == DEPTH_L);
  assign EMPTY  = (level == '0);
  assign OVF    = ovf;
  assign UNF    = unf;

endmodule
